// File: rtl/uart_axi_pkg.sv
// Shared definitions for the UARTlite-compatible AXI4-lite register map.
// Address values are common to uart_rx, uart_tx and uart_axi_responder.
package uart_axi_pkg;

  typedef enum logic [3:0] {
    RX_FIFO  = 4'h0,
    TX_FIFO  = 4'h4,
    STAT_REG = 4'h8,
    CTRL_REG = 4'hC
  } uart_addr_e;

  // STAT_REG bit positions
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_FRAME    = 6;
  localparam int STAT_PARITY   = 7;

  // CTRL_REG bit positions
  localparam int CTRL_RST_TX  = 0;
  localparam int CTRL_RST_RX  = 1;
  localparam int CTRL_INTR_EN = 4;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  typedef enum logic {
    W_COLLECT,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/uart_axi_responder_if.sv
// AXI4-lite bus between a uart_axi master and the responder.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1; valid, once raised, holds its payload until that edge.
interface uart_axi_responder_if #(
  parameter int AW = 4
);
  logic [AW-1:0] uart_axi_araddr;
  logic          uart_axi_arvalid;
  logic          uart_axi_arready;
  logic [31:0]   uart_axi_rdata;
  logic [1:0]    uart_axi_rresp;
  logic          uart_axi_rvalid;
  logic          uart_axi_rready;
  logic [AW-1:0] uart_axi_awaddr;
  logic          uart_axi_awvalid;
  logic          uart_axi_awready;
  logic [31:0]   uart_axi_wdata;
  logic [3:0]    uart_axi_wstrb;
  logic          uart_axi_wvalid;
  logic          uart_axi_wready;
  logic [1:0]    uart_axi_bresp;
  logic          uart_axi_bvalid;
  logic          uart_axi_bready;

  uart_axi_pkg::rd_state_e dbg_rd_state;
  uart_axi_pkg::wr_state_e dbg_wr_state;

  modport slave (
    input  uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
    input  uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb,
    input  uart_axi_wvalid, uart_axi_bready,
    output uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid,
    output uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
    output dbg_rd_state, dbg_wr_state
  );

  modport master (
    output uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
    output uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb,
    output uart_axi_wvalid, uart_axi_bready,
    input  uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid,
    input  uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
    input  dbg_rd_state, dbg_wr_state
  );
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with single-cycle flush; a push into a full FIFO succeeds only
// when a pop happens in the same cycle. dout reads 0 while empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_count;
  logic [7:0]    r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign count = r_count;
  assign full  = (r_count == (PW + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = empty ? 8'h00 : r_mem[r_rp];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/uart_axi_responder.sv
// AXI4-lite slave emulating the UARTlite register map, buffering bytes
// between the register interface and a byte-stream serial PHY.
module uart_axi_responder
  import uart_axi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_axi_responder_if.slave bus,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_valid,
  output logic [7:0]          tx_byte,
  output logic                tx_byte_valid,
  input  logic                tx_byte_ready,
  output logic                intr
);
  localparam int CW = $clog2(DEPTH) + 1;

  rd_state_e     r_rstate;
  rd_state_e     w_rstate_nxt;
  wr_state_e     r_wstate;
  wr_state_e     w_wstate_nxt;

  logic [AW-1:0] w_araddr;
  logic [AW-1:0] w_awaddr;
  uart_addr_e    w_ar_sel;
  logic          w_ar_hs;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_wr_exec;
  logic [31:0]   w_rd_word;
  logic [31:0]   r_rdata;
  logic [7:0]    w_stat;

  logic          r_aw_got;
  logic          r_w_got;
  uart_addr_e    r_waddr;
  logic [7:0]    r_wdata;
  logic          r_wstrb0;
  logic          w_wr_ctrl;

  logic          r_intr_en;
  logic          r_overrun;
  logic          w_ovr_set;
  logic          w_ovr_clr;
  logic          r_rx_valid_d;
  logic          r_tx_empty_d;
  logic          r_tx_pop_d;
  logic          r_intr;

  logic          w_rx_pop;
  logic          w_rx_push;
  logic          w_flush_rx;
  logic [7:0]    w_rx_dout;
  logic [CW-1:0] w_rx_count;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_flush_tx;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_unused;

  assign w_araddr = bus.uart_axi_araddr;
  assign w_awaddr = bus.uart_axi_awaddr;
  assign w_unused = &{1'b0, w_araddr, w_awaddr, bus.uart_axi_wdata[31:8],
                      bus.uart_axi_wstrb[3:1], w_rx_count, w_tx_count};

  // ---------------- read channel ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (bus.uart_axi_arvalid) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.uart_axi_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_stat                = '0;
    w_stat[STAT_RX_VALID] = !w_rx_empty;
    w_stat[STAT_RX_FULL]  = w_rx_full;
    w_stat[STAT_TX_EMPTY] = w_tx_empty;
    w_stat[STAT_TX_FULL]  = w_tx_full;
    w_stat[STAT_INTR_EN]  = r_intr_en;
    w_stat[STAT_OVERRUN]  = r_overrun;
    w_stat[STAT_FRAME]    = 1'b0;
    w_stat[STAT_PARITY]   = 1'b0;
  end

  // Side effects (RX pop, overrun clear) happen in the AR handshake cycle.
  always_comb begin
    w_rd_word = '0;
    w_rx_pop  = 1'b0;
    w_ovr_clr = 1'b0;
    w_ar_sel  = uart_addr_e'({w_araddr[3:2], 2'b00});
    if (w_ar_hs) begin
      case (w_ar_sel)
        RX_FIFO: begin
          if (!w_rx_empty) begin
            w_rd_word = {24'h0, w_rx_dout};
            w_rx_pop  = 1'b1;
          end
        end
        STAT_REG: begin
          w_rd_word = {24'h0, w_stat};
          w_ovr_clr = 1'b1;
        end
        default: w_rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rdata <= '0;
    else if (w_ar_hs) r_rdata <= w_rd_word;
  end

  assign bus.uart_axi_arready = (r_rstate == R_IDLE);
  assign bus.uart_axi_rvalid  = (r_rstate == R_RESP);
  assign bus.uart_axi_rdata   = r_rdata;
  assign bus.uart_axi_rresp   = OKAY;
  assign bus.dbg_rd_state     = r_rstate;

  // ---------------- write channel ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_COLLECT;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_exec    = 1'b0;
    case (r_wstate)
      W_COLLECT: begin
        if (r_aw_got && r_w_got) begin
          w_wr_exec    = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.uart_axi_bready) w_wstate_nxt = W_COLLECT;
      end
      default: w_wstate_nxt = W_COLLECT;
    endcase
  end

  assign bus.uart_axi_awready = (r_wstate == W_COLLECT) && !r_aw_got;
  assign bus.uart_axi_wready  = (r_wstate == W_COLLECT) && !r_w_got;
  assign bus.uart_axi_bvalid  = (r_wstate == W_RESP);
  assign bus.uart_axi_bresp   = OKAY;
  assign bus.dbg_wr_state     = r_wstate;

  assign w_aw_hs = bus.uart_axi_awready && bus.uart_axi_awvalid;
  assign w_w_hs  = bus.uart_axi_wready && bus.uart_axi_wvalid;

  // AW and W are captured independently; both flags clear once the write executes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_waddr  <= RX_FIFO;
      r_wdata  <= '0;
      r_wstrb0 <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_waddr  <= uart_addr_e'({w_awaddr[3:2], 2'b00});
      end else if (w_wr_exec) begin
        r_aw_got <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_got  <= 1'b1;
        r_wdata  <= bus.uart_axi_wdata[7:0];
        r_wstrb0 <= bus.uart_axi_wstrb[0];
      end else if (w_wr_exec) begin
        r_w_got <= 1'b0;
      end
    end
  end

  assign w_wr_ctrl  = w_wr_exec && r_wstrb0 && (r_waddr == CTRL_REG);
  assign w_tx_push  = w_wr_exec && r_wstrb0 && (r_waddr == TX_FIFO);
  assign w_flush_tx = w_wr_ctrl && r_wdata[CTRL_RST_TX];
  assign w_flush_rx = w_wr_ctrl && r_wdata[CTRL_RST_RX];

  // ---------------- FIFOs and PHY side ----------------
  assign w_rx_push     = rx_byte_valid;
  assign w_tx_pop      = tx_byte_valid && tx_byte_ready;
  assign tx_byte_valid = !w_tx_empty;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .flush (w_flush_rx),
    .din   (rx_byte),
    .dout  (w_rx_dout),
    .count (w_rx_count),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .flush (w_flush_tx),
    .din   (r_wdata),
    .dout  (tx_byte),
    .count (w_tx_count),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  // A byte lost to a full RX FIFO counts as overrun; one lost to a flush does not.
  assign w_ovr_set = rx_byte_valid && w_rx_full && !w_rx_pop && !w_flush_rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_intr_en    <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_valid_d <= 1'b0;
      r_tx_empty_d <= 1'b1;
      r_tx_pop_d   <= 1'b0;
      r_intr       <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_intr_en <= r_wdata[CTRL_INTR_EN];
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (w_ovr_clr) r_overrun <= 1'b0;
      r_rx_valid_d <= !w_rx_empty;
      r_tx_empty_d <= w_tx_empty;
      r_tx_pop_d   <= w_tx_pop;
      r_intr       <= r_intr_en &&
                      ((!w_rx_empty && !r_rx_valid_d) ||
                       (w_tx_empty && !r_tx_empty_d && r_tx_pop_d));
    end
  end

  assign intr = r_intr;
endmodule

// File: tb/tb_uart_axi_responder.sv
// Directed bench for uart_axi_responder: read data is checked by a monitor
// against an expected queue filled when each read is issued.
module tb_uart_axi_responder;
  import uart_axi_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_ready;
  logic       intr;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [1:0]   b_exp_q[$];
  logic [W-1:0] mon_e;
  string        mon_nm;
  logic [1:0]   mon_b;

  uart_axi_responder_if #(.AW(4)) bus ();

  uart_axi_responder #(.DEPTH(16), .AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready),
    .intr          (intr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.uart_axi_rvalid && bus.uart_axi_rready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.uart_axi_rdata);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if (bus.uart_axi_rdata !== mon_e || bus.uart_axi_rresp !== OKAY) begin
          n_err++;
          $display("FAIL %s: got 0x%0h resp %0d, expected 0x%0h resp 0",
                   mon_nm, bus.uart_axi_rdata, bus.uart_axi_rresp, mon_e);
        end
      end
    end
    if (!rst && bus.uart_axi_bvalid && bus.uart_axi_bready) begin
      n_cmp++;
      if (b_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected_b: got bresp %0d, expected no response", bus.uart_axi_bresp);
      end else begin
        mon_b = b_exp_q.pop_front();
        if (bus.uart_axi_bresp !== mon_b) begin
          n_err++;
          $display("FAIL wr_bresp: got %0d, expected %0d", bus.uart_axi_bresp, mon_b);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string nm);
    int cyc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    bus.uart_axi_araddr  = a;
    bus.uart_axi_arvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.uart_axi_arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_arready"}, 32'(bus.uart_axi_arready), 32'd1);
    @(posedge clk); #1;
    bus.uart_axi_arvalid = 1'b0;
    @(negedge clk);
    check({nm, "_rvalid_lat"}, 32'(bus.uart_axi_rvalid), 32'd1);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [7:0] d, input logic s);
    bit aw_done;
    bit w_done;
    int cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    b_exp_q.push_back(OKAY);
    @(posedge clk); #1;
    bus.uart_axi_awaddr  = a;
    bus.uart_axi_awvalid = 1'b1;
    bus.uart_axi_wdata   = {24'hA5A5A5, d};
    bus.uart_axi_wstrb   = {3'b111, s};
    bus.uart_axi_wvalid  = 1'b1;
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      @(negedge clk);
      if (bus.uart_axi_awvalid && bus.uart_axi_awready) aw_done = 1'b1;
      if (bus.uart_axi_wvalid && bus.uart_axi_wready)   w_done  = 1'b1;
      @(posedge clk); #1;
      if (aw_done) bus.uart_axi_awvalid = 1'b0;
      if (w_done)  bus.uart_axi_wvalid  = 1'b0;
      cyc++;
    end
    check("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    cyc = 0;
    @(negedge clk);
    while (!bus.uart_axi_bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_bvalid", 32'(bus.uart_axi_bvalid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int cyc;
    int hi;
    rst                  = 1'b1;
    rx_byte              = 8'h00;
    rx_byte_valid        = 1'b0;
    tx_byte_ready        = 1'b0;
    bus.uart_axi_araddr  = '0;
    bus.uart_axi_arvalid = 1'b0;
    bus.uart_axi_rready  = 1'b1;
    bus.uart_axi_awaddr  = '0;
    bus.uart_axi_awvalid = 1'b0;
    bus.uart_axi_wdata   = '0;
    bus.uart_axi_wstrb   = '0;
    bus.uart_axi_wvalid  = 1'b0;
    bus.uart_axi_bready  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(bus.uart_axi_arready), 32'd1);
    check("rst_awready", 32'(bus.uart_axi_awready), 32'd1);
    check("rst_wready",  32'(bus.uart_axi_wready),  32'd1);
    check("rst_rvalid",  32'(bus.uart_axi_rvalid),  32'd0);
    check("rst_bvalid",  32'(bus.uart_axi_bvalid),  32'd0);
    check("rst_rdata",   bus.uart_axi_rdata,        32'd0);
    check("rst_tx_valid", 32'(tx_byte_valid), 32'd0);
    check("rst_tx_byte",  32'(tx_byte),       32'd0);
    check("rst_intr",     32'(intr),          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    axi_read(STAT_REG, 32'h04, "stat_after_reset");

    // Two received bytes read back in order, then an empty read.
    rx_send(8'h41);
    rx_send(8'h42);
    axi_read(STAT_REG, 32'h05, "stat_two_rx");
    axi_read(RX_FIFO,  32'h41, "rx_first");
    axi_read(RX_FIFO,  32'h42, "rx_second");
    axi_read(STAT_REG, 32'h04, "stat_rx_drained");
    axi_read(RX_FIFO,  32'h00, "rx_empty_read");

    // Overfill by one: the 17th byte is dropped and overrun reported once.
    for (int i = 0; i < 17; i++) rx_send(8'(8'h10 + i));
    axi_read(STAT_REG, 32'h27, "stat_overrun");
    axi_read(STAT_REG, 32'h07, "stat_overrun_cleared");
    for (int i = 0; i < 16; i++) axi_read(RX_FIFO, 32'(16 + i), "rx_full_readback");
    axi_read(STAT_REG, 32'h04, "stat_after_full_drain");

    // TX path with the PHY stalled, then one byte consumed.
    axi_write(TX_FIFO, 8'h55, 1'b1);
    @(negedge clk);
    check("tx_valid_after_push", 32'(tx_byte_valid), 32'd1);
    check("tx_byte_head",        32'(tx_byte),       32'h55);
    axi_read(STAT_REG, 32'h00, "stat_tx_pending");
    @(posedge clk); #1;
    tx_byte_ready = 1'b1;
    @(posedge clk); #1;
    tx_byte_ready = 1'b0;
    @(negedge clk);
    check("tx_valid_after_pop", 32'(tx_byte_valid), 32'd0);
    axi_read(STAT_REG, 32'h04, "stat_tx_drained");

    // W arrives three cycles ahead of AW, bready held low for two cycles.
    bus.uart_axi_bready = 1'b0;
    b_exp_q.push_back(OKAY);
    @(posedge clk); #1;
    bus.uart_axi_awaddr = CTRL_REG;
    bus.uart_axi_wdata  = 32'h0;
    bus.uart_axi_wstrb  = 4'h1;
    bus.uart_axi_wvalid = 1'b1;
    @(negedge clk);
    check("early_w_wready", 32'(bus.uart_axi_wready), 32'd1);
    @(posedge clk); #1;
    bus.uart_axi_wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("early_w_wready_low", 32'(bus.uart_axi_wready),  32'd0);
      check("early_w_awready",    32'(bus.uart_axi_awready), 32'd1);
      check("early_w_no_bvalid",  32'(bus.uart_axi_bvalid),  32'd0);
      @(posedge clk); #1;
    end
    bus.uart_axi_awvalid = 1'b1;
    @(negedge clk);
    check("late_aw_awready", 32'(bus.uart_axi_awready), 32'd1);
    check("late_aw_no_bvalid", 32'(bus.uart_axi_bvalid), 32'd0);
    @(posedge clk); #1;
    bus.uart_axi_awvalid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.uart_axi_bvalid && cyc < 5) begin
      check("wait_b_awready", 32'(bus.uart_axi_awready), 32'd0);
      check("wait_b_wready",  32'(bus.uart_axi_wready),  32'd0);
      @(negedge clk);
      cyc++;
    end
    check("late_aw_bvalid", 32'(bus.uart_axi_bvalid), 32'd1);
    check("b_stall_awready", 32'(bus.uart_axi_awready), 32'd0);
    check("b_stall_wready",  32'(bus.uart_axi_wready),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_held_bvalid",  32'(bus.uart_axi_bvalid),  32'd1);
    check("b_held_awready", 32'(bus.uart_axi_awready), 32'd0);
    check("b_held_wready",  32'(bus.uart_axi_wready),  32'd0);
    @(posedge clk); #1;
    bus.uart_axi_bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_b_awready", 32'(bus.uart_axi_awready), 32'd1);
    check("after_b_wready",  32'(bus.uart_axi_wready),  32'd1);
    check("after_b_bvalid",  32'(bus.uart_axi_bvalid),  32'd0);

    // wstrb[0]=0 write is ignored but still answered.
    axi_write(TX_FIFO, 8'h77, 1'b0);
    @(negedge clk);
    check("wstrb0_ignored", 32'(tx_byte_valid), 32'd0);

    // Five bytes in each FIFO, then flush both and enable the interrupt.
    for (int i = 0; i < 5; i++) begin
      rx_send(8'(8'h60 + i));
      axi_write(TX_FIFO, 8'(8'h70 + i), 1'b1);
    end
    axi_read(STAT_REG, 32'h01, "stat_both_loaded");
    axi_write(CTRL_REG, 8'h13, 1'b1);
    @(negedge clk);
    check("flush_tx_valid", 32'(tx_byte_valid), 32'd0);
    check("flush_no_intr",  32'(intr),          32'd0);
    axi_read(STAT_REG, 32'h14, "stat_after_flush");
    axi_read(RX_FIFO,  32'h00, "rx_after_flush");
    rx_send(8'h99);
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (intr) hi++;
    end
    check("intr_pulse_cycles", 32'(hi), 32'd1);
    axi_read(RX_FIFO,  32'h99, "rx_after_intr");
    axi_read(STAT_REG, 32'h14, "stat_final");

    cyc = 0;
    while ((exp_q.size() != 0 || b_exp_q.size() != 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_queue_drained", 32'(exp_q.size()),   32'd0);
    check("wr_queue_drained", 32'(b_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
